// File: rtl/ysyx_23060124_ifu.sv
// Instruction fetch unit: one AXI4-Lite read per PC update, handed to decode via valid/ready.
// Optional performance counters are compiled in with YSYX_23060124_IFU_PERF_EN.
module ysyx_23060124_ifu #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pc_update,
    input  logic [ADDR_W-1:0] i_npc,
    output logic [ADDR_W-1:0] o_araddr,
    output logic              o_arvalid,
    input  logic              i_arready,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [1:0]        i_rresp,
    input  logic              i_rvalid,
    output logic              o_rready,
    output logic [DATA_W-1:0] o_ins,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_fetch_err
`ifdef YSYX_23060124_IFU_PERF_EN
    ,
    output logic [63:0]       o_fetch_cnt,
    output logic [63:0]       o_stall_cnt
`endif
);

    // state  | meaning
    // S_IDLE | just out of reset, first fetch issued next cycle
    // S_AR   | read address presented, waiting for arready
    // S_R    | waiting for read data
    // S_OUT  | instruction offered to decode
    // S_WPC  | waiting for writeback to supply the next PC
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_OUT  = 3'd3,
        S_WPC  = 3'd4
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;

    assign o_araddr = pc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            o_arvalid   <= 1'b0;
            o_rready    <= 1'b0;
            o_valid     <= 1'b0;
            o_fetch_err <= 1'b0;
            o_ins       <= '0;
            o_pc        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    o_arvalid <= 1'b1;
                    state     <= S_AR;
                end
                S_AR: begin
                    if (i_arready) begin
                        o_arvalid <= 1'b0;
                        o_rready  <= 1'b1;
                        state     <= S_R;
                    end
                end
                S_R: begin
                    // A bad response is flagged but the word still goes to decode.
                    if (i_rvalid) begin
                        o_ins    <= i_rdata;
                        o_pc     <= pc;
                        o_rready <= 1'b0;
                        o_valid  <= 1'b1;
                        state    <= S_OUT;
                        if (i_rresp != 2'b00) o_fetch_err <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= S_WPC;
                    end
                end
                S_WPC: begin
                    if (i_pc_update) begin
                        pc        <= {i_npc[ADDR_W-1:2], 2'b00};
                        o_arvalid <= 1'b1;
                        state     <= S_AR;
                        if (i_npc[1:0] != 2'b00) o_fetch_err <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge i_clk) begin
        if (!i_rst && i_pc_update && state != S_WPC)
            $warning("ifu: i_pc_update ignored in state %s", state.name());
    end
`endif

`ifdef YSYX_23060124_IFU_PERF_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_fetch_cnt <= '0;
            o_stall_cnt <= '0;
        end else begin
            if (state == S_R && i_rvalid)         o_fetch_cnt <= o_fetch_cnt + 64'd1;
            if (state == S_AR || state == S_R)    o_stall_cnt <= o_stall_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: doc/ysyx_23060124_ifu.md
Name: ysyx_23060124_ifu

Overview:
- Instruction fetch unit directly upstream of the decode stage. It holds the PC and fetches one 32-bit instruction per step over an AXI4-Lite read channel.
- It presents the fetched instruction and its PC to decode with a valid/ready handshake.
- The core is multi-cycle and non-pipelined: after handing off an instruction, the IFU waits for the writeback stage to return the next PC, then fetches again.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- ADDR_W, 32, address and PC width.
- DATA_W, 32, instruction and read-data width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_pc_update  in  1  one-cycle pulse from writeback: i_npc is valid.
- i_npc  in  ADDR_W  next PC from writeback.
- o_araddr  out  ADDR_W  AXI read address; always equals the current PC.
- o_arvalid  out  1  AXI read address valid.
- i_arready  in  1  AXI read address ready.
- i_rdata  in  DATA_W  AXI read data.
- i_rresp  in  2  AXI read response.
- i_rvalid  in  1  AXI read data valid.
- o_rready  out  1  AXI read data ready.
- o_ins  out  DATA_W  fetched instruction, to decode.
- o_pc  out  ADDR_W  PC of o_ins.
- o_valid  out  1  o_ins/o_pc valid for decode.
- i_ready  in  1  decode accepts the instruction.
- o_fetch_err  out  1  sticky: nonzero rresp or misaligned i_npc.

Behaviour:
- Reset values:
  - pc = RESET_PC; state = S_IDLE.
  - o_arvalid, o_rready, o_valid, o_fetch_err = 0.
  - o_ins = 0.
- All outputs are registered. Reset asserted mid-operation aborts any AXI transaction and returns to S_IDLE. The bus slave must also be reset.
- State machine (registered):
  - S_IDLE: next cycle → S_AR, with o_arvalid = 1.
  - S_AR:
    - o_arvalid held high; o_araddr stable.
    - On i_arready, drop o_arvalid, raise o_rready → S_R.
    - i_arready may arrive in the first S_AR cycle.
  - S_R:
    - o_rready high. On i_rvalid, capture o_ins = i_rdata and o_pc = pc, drop o_rready, raise o_valid → S_OUT.
    - If i_rresp != 0, set o_fetch_err. The instruction is still forwarded.
  - S_OUT:
    - o_valid held with o_ins/o_pc stable until i_ready.
    - On the i_valid & i_ready cycle, o_valid → 0 next cycle → S_WPC.
    - If i_ready is already high on the first S_OUT cycle, the transfer completes in one cycle.
  - S_WPC: on i_pc_update, pc = i_npc → S_AR with o_arvalid = 1.
- Fetch latency:
  - Minimum 3 cycles from the pc update to o_valid, with zero-wait arready and rvalid: S_AR 1 cycle, S_R 1 cycle, o_valid in the following cycle.
  - The decode handoff is one additional cycle.
- i_pc_update outside S_WPC:
  - Ignored; pc is unchanged.
  - In simulation only, print a warning with the current state.
- i_npc with bits [1:0] != 0:
  - Set o_fetch_err; pc loads {i_npc[31:2], 2'b00}.
  - Fetch continues.
- o_fetch_err is cleared only by reset.
- i_rvalid arriving while not in S_R is ignored (protocol violation); o_rready stays 0.
- pc increments only via i_npc. The IFU never computes pc+4 itself.
- No outstanding transactions beyond one. The AXI write channel is unused and not ported.

Optional Feature:
- Macro: YSYX_23060124_IFU_PERF_EN.
- When defined, add these outputs:
  - o_fetch_cnt (64): increments on each S_R→S_OUT transition.
  - o_stall_cnt (64): increments every cycle spent in S_AR or S_R.
  - Both counters reset to 0 and wrap modulo 2^64.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Release reset; arready=1 immediately; rvalid=1 one cycle later with rdata=32'h00000413, rresp=0; i_ready=1.
  - → o_araddr=32'h8000_0000; o_valid with o_ins=32'h00000413, o_pc=32'h8000_0000; then state S_WPC, o_arvalid=0.
- In S_WPC, pulse i_pc_update with i_npc=32'h8000_0004; arready delayed 3 cycles; rvalid delayed 2 cycles.
  - → o_arvalid held 4 cycles with o_araddr=32'h8000_0004; o_rready high until rvalid; o_pc=32'h8000_0004.
- o_valid high with i_ready=0 for 5 cycles, then 1.
  - → o_ins/o_pc stable for all 6 cycles; o_valid drops the cycle after acceptance.
- Fetch with rresp=2'b10.
  - → o_fetch_err=1 and stays set through later fetches until i_rst.
- Pulse i_pc_update=1, i_npc=32'h8000_0100 while in S_R.
  - → ignored; the next i_pc_update in S_WPC with i_npc=32'h8000_0102 → o_fetch_err=1, o_araddr=32'h8000_0100.
- Assert i_rst mid-S_R, asynchronously between clock edges.
  - → o_rready, o_valid, o_arvalid = 0 immediately; pc=RESET_PC; the fetch restarts from 32'h8000_0000 after release.
  - With YSYX_23060124_IFU_PERF_EN defined, o_fetch_cnt=0.
